spi_bit_sequencer: RTL and testbench
====================================

# spi_bit_sequencer

Transaction controller for the SPI master datapath. It accepts a byte over a start/busy handshake, latches it, and steps the 3-bit select of the downstream 8:1 bit mux so that the mux output becomes MOSI. It also generates SCLK (mode 0) and CS_N, and shifts MISO into a receive byte. The block sits directly upstream of the bit mux: it drives the mux's `in[7:0]` from `tx_latch` and its `sel[2:0]` from `sel`, and it treats the mux output as MOSI.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCLK half-period; legal range 1..255.
- `CS_SETUP`, default 2: clk cycles of CS_N-low before the first SCLK edge, and again after the last; legal range 1..255.
- `MSB_FIRST`, default 1: 1 sends bit 7 first (sel 7→0); 0 sends bit 0 first (sel 0→7).
- `clk` in 1: single system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a transaction; sampled only in IDLE.
- `tx_byte` in 8: byte to send; captured in the cycle `start` is accepted.
- `miso` in 1: serial input, already synchronous to `clk`.
- `tx_latch` out 8: held transmit byte; drives the mux data input.
- `sel` out 3: bit index; drives the mux select.
- `sclk` out 1: SPI clock; idles low.
- `cs_n` out 1: chip select, active low.
- `busy` out 1: high from acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse when `rx_byte` is valid.
- `rx_byte` out 8: received byte; holds its value until the next `done`.

## Operation
- Reset values: `tx_latch`=0, `sel`=0, `sclk`=0, `cs_n`=1, `busy`=0, `done`=0, `rx_byte`=0. The state returns to IDLE and all counters clear.
- Internal counters: `div_cnt` (8 bit, counts 0..CLK_DIV-1), `cs_cnt` (8 bit), `bit_cnt` (3 bit).
- Register `rx_sh` (8 bit) collects MISO; its bit ordering follows MSB_FIRST.
- **IDLE**
  - When `start`=1: latch `tx_byte` into `tx_latch`.
  - Set `sel` to 7 if MSB_FIRST, else 0.
  - Assert `cs_n`=0 and `busy`=1, then go to SETUP.
- **SETUP**
  - Stay CS_SETUP cycles with `sclk`=0, then go to SHIFT_LO.
- **SHIFT_LO**
  - Stay CLK_DIV cycles with `sclk`=0.
  - On exit, set `sclk`=1 and sample `miso` into `rx_sh`:
    - MSB_FIRST=1: left shift, new bit enters at bit 0.
    - MSB_FIRST=0: right shift, new bit enters at bit 7.
  - Then go to SHIFT_HI.
- **SHIFT_HI**
  - Stay CLK_DIV cycles with `sclk`=1.
  - On exit, set `sclk`=0.
  - If `bit_cnt`=7, go to HOLD; `sel` is left unchanged.
  - Otherwise increment `bit_cnt`, step `sel` (decrement if MSB_FIRST, else increment), and go to SHIFT_LO.
- **HOLD**
  - Stay CS_SETUP cycles with `cs_n`=0 and `sclk`=0.
  - On exit, set `cs_n`=1, copy `rx_sh` to `rx_byte`, set `done`=1, and go to DONE.
- **DONE**
  - Lasts one cycle with `done`=1 and `busy`=1.
  - Next cycle: `done`=0, `busy`=0, state IDLE.
- `start` is ignored in every state other than IDLE; no queueing.
- `tx_latch` is stable from acceptance until the next acceptance; changes on `tx_byte` while busy have no effect.
- `sel` never wraps: it covers exactly 8 values per transaction and stays at its final value (0 or 7) until the next acceptance.
- Reset asserted mid-transaction: outputs go to their reset values immediately, the partial `rx_sh` is discarded, and no `done` pulse is produced.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Acceptance at cycle edge N: `cs_n`, `busy`, `sel` and `tx_latch` are valid at N+1.
- First SCLK rise occurs at N+1+CS_SETUP+CLK_DIV.
- Bit period is 2·CLK_DIV cycles.
- `sel` changes only on the same edge as an SCLK falling edge, so MOSI is stable a full half-period before each rising edge.
- MISO is sampled on the clk edge that raises SCLK.
- `done` is high at N+1+2·CS_SETUP+16·CLK_DIV. `busy` falls one cycle later.
- Earliest next acceptance is the cycle after `busy` falls, giving CS_N a minimum high time of 2 cycles.

## Test plan
- Reset then idle: hold `reset_n`=0 for 3 cycles, release -> all outputs at reset values; no SCLK edges for 20 cycles.
- Loopback, MSB first: CLK_DIV=2, CS_SETUP=1, tie `miso` to the mux output, `tx_byte`=0xA5 -> `sel` runs 7,6,…,0; MOSI bits are 1,0,1,0,0,1,0,1; exactly 8 SCLK rises; `done` 35 cycles after acceptance; `rx_byte`=0xA5.
- LSB first: MSB_FIRST=0, `tx_byte`=0x3C, `miso` driven with 0x96 presented LSB first -> `sel` runs 0..7; MOSI bits are 0,0,1,1,1,1,0,0; `rx_byte`=0x96.
- Start while busy: pulse `start` with 0x11 mid-transfer of 0xF0 -> ignored; `tx_latch` stays 0xF0; exactly one `done`.
- Back-to-back: hold `start` high with 0x55 then 0xAA -> second acceptance the cycle after `busy` falls; CS_N high for exactly 2 cycles; both bytes are sent correctly.
- Reset mid-transfer: assert `reset_n`=0 after the 4th SCLK rise -> `cs_n`=1 and `sclk`=0 asynchronously; no `done`; `rx_byte`=0; a fresh transaction afterwards completes normally.

Source files
------------

// File: rtl/spi_bit_sequencer.sv
// SPI mode-0 master sequencer: latches a byte, walks the downstream 8:1 bit-mux select,
// generates SCLK/CS_N and shifts MISO into a receive byte.
module spi_bit_sequencer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] tx_latch,
    output logic [2:0] sel,
    output logic       sclk,
    output logic       cs_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] CS_LAST   = 8'(CS_SETUP - 1);
    localparam logic [2:0] SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;

    state_t     r_state;
    logic [7:0] r_div_cnt;
    logic [7:0] r_cs_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_sh;
    logic [7:0] r_tx_latch;
    logic [2:0] r_sel;
    logic       r_sclk;
    logic       r_cs_n;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_rx_byte;

    state_t     w_state_next;
    logic [7:0] w_div_cnt_next;
    logic [7:0] w_cs_cnt_next;
    logic [2:0] w_bit_cnt_next;
    logic [7:0] w_rx_sh_next;
    logic [7:0] w_tx_latch_next;
    logic [2:0] w_sel_next;
    logic       w_sclk_next;
    logic       w_cs_n_next;
    logic       w_busy_next;
    logic       w_done_next;
    logic [7:0] w_rx_byte_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_cs_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_rx_sh    <= '0;
            r_tx_latch <= '0;
            r_sel      <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_div_cnt  <= w_div_cnt_next;
            r_cs_cnt   <= w_cs_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_rx_sh    <= w_rx_sh_next;
            r_tx_latch <= w_tx_latch_next;
            r_sel      <= w_sel_next;
            r_sclk     <= w_sclk_next;
            r_cs_n     <= w_cs_n_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_rx_byte  <= w_rx_byte_next;
        end
    end

    // Next values of every register are computed here so all outputs stay registered.
    always_comb begin
        w_state_next    = r_state;
        w_div_cnt_next  = r_div_cnt;
        w_cs_cnt_next   = r_cs_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_rx_sh_next    = r_rx_sh;
        w_tx_latch_next = r_tx_latch;
        w_sel_next      = r_sel;
        w_sclk_next     = r_sclk;
        w_cs_n_next     = r_cs_n;
        w_busy_next     = r_busy;
        w_done_next     = r_done;
        w_rx_byte_next  = r_rx_byte;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_tx_latch_next = tx_byte;
                    w_sel_next      = SEL_FIRST;
                    w_cs_n_next     = 1'b0;
                    w_busy_next     = 1'b1;
                    w_cs_cnt_next   = '0;
                    w_div_cnt_next  = '0;
                    w_bit_cnt_next  = '0;
                    w_rx_sh_next    = '0;
                    w_state_next    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cs_cnt == CS_LAST) begin
                    w_cs_cnt_next  = '0;
                    w_div_cnt_next = '0;
                    w_state_next   = S_SHIFT_LO;
                end else begin
                    w_cs_cnt_next = r_cs_cnt + 8'd1;
                end
            end
            S_SHIFT_LO: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_next = '0;
                    w_sclk_next    = 1'b1;
                    w_rx_sh_next   = MSB_FIRST ? {r_rx_sh[6:0], miso} : {miso, r_rx_sh[7:1]};
                    w_state_next   = S_SHIFT_HI;
                end else begin
                    w_div_cnt_next = r_div_cnt + 8'd1;
                end
            end
            S_SHIFT_HI: begin
                // sel only moves on the falling SCLK edge so MOSI settles a full half-period early.
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_next = '0;
                    w_sclk_next    = 1'b0;
                    if (r_bit_cnt == 3'd7) begin
                        w_cs_cnt_next = '0;
                        w_state_next  = S_HOLD;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        w_sel_next     = MSB_FIRST ? r_sel - 3'd1 : r_sel + 3'd1;
                        w_state_next   = S_SHIFT_LO;
                    end
                end else begin
                    w_div_cnt_next = r_div_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                if (r_cs_cnt == CS_LAST) begin
                    w_cs_cnt_next  = '0;
                    w_cs_n_next    = 1'b1;
                    w_rx_byte_next = r_rx_sh;
                    w_done_next    = 1'b1;
                    w_state_next   = S_DONE;
                end else begin
                    w_cs_cnt_next = r_cs_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_done_next  = 1'b0;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign tx_latch = r_tx_latch;
    assign sel      = r_sel;
    assign sclk     = r_sclk;
    assign cs_n     = r_cs_n;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_byte  = r_rx_byte;

endmodule

// File: tb/tb_spi_bit_sequencer.sv
// Directed bench for spi_bit_sequencer: one MSB-first and one LSB-first instance,
// CLK_DIV=2 and CS_SETUP=1, so done lands 35 cycles after acceptance.
module tb_spi_bit_sequencer;

    typedef struct {
        int         d;
        logic [7:0] tx;
        bit         loopback;
        logic [7:0] rxPat;
        logic [7:0] expMosi;
        logic [7:0] expRx;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start  [2];
    logic [7:0] txByte [2];
    logic       miso   [2];
    logic [7:0] txLatch[2];
    logic [2:0] sel    [2];
    logic       sclk   [2];
    logic       csN    [2];
    logic       busy   [2];
    logic       done   [2];
    logic [7:0] rxByte [2];

    int checks   = 0;
    int failures = 0;

    spi_bit_sequencer #(.CLK_DIV(2), .CS_SETUP(1), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .reset_n(resetN), .start(start[0]), .tx_byte(txByte[0]), .miso(miso[0]),
        .tx_latch(txLatch[0]), .sel(sel[0]), .sclk(sclk[0]), .cs_n(csN[0]),
        .busy(busy[0]), .done(done[0]), .rx_byte(rxByte[0])
    );

    spi_bit_sequencer #(.CLK_DIV(2), .CS_SETUP(1), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .reset_n(resetN), .start(start[1]), .tx_byte(txByte[1]), .miso(miso[1]),
        .tx_latch(txLatch[1]), .sel(sel[1]), .sclk(sclk[1]), .cs_n(csN[1]),
        .busy(busy[1]), .done(done[1]), .rx_byte(rxByte[1])
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveMiso(input int d, input bit loopback, input logic [7:0] pat, input int rises);
        if (loopback) miso[d] = txLatch[d][sel[d]];
        else if (rises < 8) miso[d] = (d == 0) ? pat[7 - rises] : pat[rises];
        else miso[d] = 1'b0;
    endtask

    // One full transaction; cycle c is the c-th cycle after the acceptance cycle.
    task automatic applyStimulus(input vec_t v, input string tag);
        int         d          = v.d;
        int         rises      = 0;
        int         firstRise  = -1;
        int         doneCycle  = -1;
        logic       prevSclk   = 1'b0;
        logic [7:0] mosiSeq    = '0;
        logic [23:0] selSeq    = '0;
        logic [23:0] expSel    = '0;
        bit         latchOk    = 1'b1;
        for (int k = 0; k < 8; k++) expSel = {expSel[20:0], (d == 0) ? 3'(7 - k) : 3'(k)};

        @(negedge clk);
        txByte[d] = v.tx;
        start[d]  = 1'b1;
        driveMiso(d, 1'b0, v.rxPat, 0);
        @(posedge clk);
        for (int c = 1; c <= 60 && doneCycle < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start[d]  = 1'b0;
                txByte[d] = ~v.tx;
                checkOutput({tag, "_csN_accept"}, 32'(csN[d]), 32'd0);
                checkOutput({tag, "_busy_accept"}, 32'(busy[d]), 32'd1);
                checkOutput({tag, "_sel_first"}, 32'(sel[d]), (d == 0) ? 32'd7 : 32'd0);
            end
            if (sclk[d] && !prevSclk) begin
                if (rises == 0) firstRise = c;
                mosiSeq = {mosiSeq[6:0], txLatch[d][sel[d]]};
                selSeq  = {selSeq[20:0], sel[d]};
                rises++;
            end
            prevSclk = sclk[d];
            if (txLatch[d] !== v.tx) latchOk = 1'b0;
            if (done[d]) doneCycle = c;
            driveMiso(d, v.loopback, v.rxPat, rises);
        end
        checkOutput({tag, "_doneCycle"}, 32'(doneCycle), 32'd35);
        checkOutput({tag, "_firstRise"}, 32'(firstRise), 32'd4);
        checkOutput({tag, "_rises"}, 32'(rises), 32'd8);
        checkOutput({tag, "_mosi"}, 32'(mosiSeq), 32'(v.expMosi));
        checkOutput({tag, "_selSeq"}, 32'(selSeq), 32'(expSel));
        checkOutput({tag, "_rxByte"}, 32'(rxByte[d]), 32'(v.expRx));
        checkOutput({tag, "_txLatchStable"}, 32'(latchOk), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_doneFall"}, 32'(done[d]), 32'd0);
        checkOutput({tag, "_busyFall"}, 32'(busy[d]), 32'd0);
        checkOutput({tag, "_csNHigh"}, 32'(csN[d]), 32'd1);
        checkOutput({tag, "_selFinal"}, 32'(sel[d]), (d == 0) ? 32'd0 : 32'd7);
        checkOutput({tag, "_rxHold"}, 32'(rxByte[d]), 32'(v.expRx));
    endtask

    initial begin
        vec_t       vecs[6];
        int         rises;
        int         dones;
        int         csHigh;
        int         acceptCycle;
        int         secondDone;
        int         busyLow;
        int         sclkRises;
        bit         latchOk;
        logic       prevSclk;
        logic [15:0] mosi16;
        logic [7:0] rxFirst;
        logic [7:0] rxSecond;

        // MOSI columns pack the transmitted bits in wire order, first bit at the MSB.
        vecs[0] = '{0, 8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{1, 8'h3C, 1'b0, 8'h96, 8'h3C, 8'h96};
        vecs[2] = '{0, 8'h81, 1'b0, 8'h4E, 8'h81, 8'h4E};
        vecs[3] = '{1, 8'h01, 1'b0, 8'hC3, 8'h80, 8'hC3};
        vecs[4] = '{1, 8'hB2, 1'b1, 8'h00, 8'h4D, 8'hB2};
        vecs[5] = '{0, 8'h00, 1'b0, 8'hFF, 8'h00, 8'hFF};

        resetN = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d]  = 1'b0;
            txByte[d] = 8'h00;
            miso[d]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset%0d_txLatch", d), 32'(txLatch[d]), 32'd0);
            checkOutput($sformatf("reset%0d_sel", d), 32'(sel[d]), 32'd0);
            checkOutput($sformatf("reset%0d_sclk", d), 32'(sclk[d]), 32'd0);
            checkOutput($sformatf("reset%0d_csN", d), 32'(csN[d]), 32'd1);
            checkOutput($sformatf("reset%0d_busy", d), 32'(busy[d]), 32'd0);
            checkOutput($sformatf("reset%0d_done", d), 32'(done[d]), 32'd0);
            checkOutput($sformatf("reset%0d_rxByte", d), 32'(rxByte[d]), 32'd0);
        end
        sclkRises = 0;
        repeat (20) begin
            @(negedge clk);
            if (sclk[0] || sclk[1] || !csN[0] || !csN[1]) sclkRises++;
        end
        checkOutput("idle_noActivity", 32'(sclkRises), 32'd0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // A second start mid-transfer must be dropped, not queued.
        @(negedge clk);
        txByte[0] = 8'hF0;
        start[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        txByte[0] = 8'h11;
        start[0]  = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        dones    = 0;
        latchOk  = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done[0]) dones++;
            if (txLatch[0] !== 8'hF0) latchOk = 1'b0;
        end
        checkOutput("busyStart_doneCount", 32'(dones), 32'd1);
        checkOutput("busyStart_txLatch", 32'(latchOk), 32'd1);
        checkOutput("busyStart_idle", 32'(busy[0]), 32'd0);

        // Start held high across two transfers with loopback MISO.
        @(negedge clk);
        txByte[0] = 8'h55;
        start[0]  = 1'b1;
        miso[0]   = 1'b0;
        @(posedge clk);
        dones = 0; csHigh = 0; acceptCycle = -1; secondDone = -1; busyLow = 0;
        mosi16 = '0; rxFirst = '0; rxSecond = '0; prevSclk = 1'b0;
        for (int c = 1; c <= 120 && secondDone < 0; c++) begin
            @(negedge clk);
            if (c == 1) txByte[0] = 8'hAA;
            if (sclk[0] && !prevSclk) mosi16 = {mosi16[14:0], txLatch[0][sel[0]]};
            prevSclk = sclk[0];
            if (done[0]) begin
                dones++;
                if (dones == 1) rxFirst = rxByte[0];
                else begin
                    rxSecond   = rxByte[0];
                    secondDone = c;
                end
            end
            if (dones == 1 && acceptCycle < 0) begin
                if (csN[0]) csHigh++;
                else begin
                    acceptCycle = c;
                    start[0]    = 1'b0;
                end
                if (!busy[0]) busyLow++;
            end
            miso[0] = txLatch[0][sel[0]];
        end
        start[0] = 1'b0;
        checkOutput("b2b_csNHighCycles", 32'(csHigh), 32'd2);
        checkOutput("b2b_busyLowCycles", 32'(busyLow), 32'd1);
        checkOutput("b2b_secondAccept", 32'(acceptCycle), 32'd37);
        checkOutput("b2b_secondDone", 32'(secondDone), 32'd71);
        checkOutput("b2b_mosi", 32'(mosi16), 32'h55AA);
        checkOutput("b2b_rxFirst", 32'(rxFirst), 32'h55);
        checkOutput("b2b_rxSecond", 32'(rxSecond), 32'hAA);

        // Asynchronous reset after the 4th SCLK rise.
        @(negedge clk);
        txByte[0] = 8'hC3;
        start[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        rises = 0; prevSclk = 1'b0;
        for (int c = 0; c < 60 && rises < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (sclk[0] && !prevSclk) rises++;
            prevSclk = sclk[0];
            miso[0]  = txLatch[0][sel[0]];
        end
        checkOutput("midReset_reachedRise4", 32'(rises), 32'd4);
        #2 resetN = 1'b0;
        #1;
        checkOutput("midReset_csN", 32'(csN[0]), 32'd1);
        checkOutput("midReset_sclk", 32'(sclk[0]), 32'd0);
        checkOutput("midReset_busy", 32'(busy[0]), 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[0]) dones++;
        end
        resetN = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done[0]) dones++;
        end
        checkOutput("midReset_noDone", 32'(dones), 32'd0);
        checkOutput("midReset_rxByte", 32'(rxByte[0]), 32'd0);
        applyStimulus('{0, 8'h5A, 1'b1, 8'h00, 8'h5A, 8'h5A}, "afterReset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
